// File: rtl/port_pkg.sv
// ---------------------------------------------------------------------------
// port_pkg
// Shared constants and helpers for the EMC08 GPIO port SFR block.
//   PORT_W          : pins per port
//   *_OFS           : register offsets from the block's base SFR address
//   EDGE_RISE/FALL  : encoding of a PXIES bit
//   reg_sel_e       : decoded register select
//   decode_reg()    : maps an SFR address to a register select
// ---------------------------------------------------------------------------
package port_pkg;

    localparam int PORT_W = 8;

    localparam logic [7:0] PX_OFS    = 8'd0;
    localparam logic [7:0] PXEN_OFS  = 8'd1;
    localparam logic [7:0] PXIE_OFS  = 8'd2;
    localparam logic [7:0] PXIES_OFS = 8'd3;
    localparam logic [7:0] PXIF_OFS  = 8'd4;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic [2:0] {
        REG_PX    = 3'd0,
        REG_PXEN  = 3'd1,
        REG_PXIE  = 3'd2,
        REG_PXIES = 3'd3,
        REG_PXIF  = 3'd4,
        REG_NONE  = 3'd7
    } reg_sel_e;

    // The offset is computed modulo 256, so addresses below the base wrap to
    // large offsets and fall through to REG_NONE.
    function automatic reg_sel_e decode_reg(input logic [7:0] addr,
                                            input logic [7:0] base);
        logic [7:0] ofs;
        ofs = addr - base;
        case (ofs)
            PX_OFS:    return REG_PX;
            PXEN_OFS:  return REG_PXEN;
            PXIE_OFS:  return REG_PXIE;
            PXIES_OFS: return REG_PXIES;
            PXIF_OFS:  return REG_PXIF;
            default:   return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/port_sfr_ctrl_if.sv
// ---------------------------------------------------------------------------
// port_sfr_ctrl_if
// CPU SFR bus as seen by one GPIO port block.
//   sfr_addr_i  : SFR address
//   sfr_wr_i    : write strobe
//   sfr_rd_i    : read strobe
//   sfr_wdata_i : write data
//   sfr_rdata_o : registered read data
//   sfr_hit_o   : registered, marks sfr_rdata_o as valid for this block
//
// Bus semantics: there is no back-pressure. A strobe (sfr_wr_i or sfr_rd_i)
// is a single-cycle request that is always accepted on the rising edge where
// it is high. A write takes effect on that edge. A read returns data on the
// following cycle, qualified by sfr_hit_o for exactly one cycle; in every
// other cycle sfr_rdata_o is 8'h00 and sfr_hit_o is 0. Both strobes together
// perform the write and return the pre-write contents.
// ---------------------------------------------------------------------------
interface port_sfr_ctrl_if;
    import port_pkg::*;

    logic [7:0]        sfr_addr_i;
    logic              sfr_wr_i;
    logic              sfr_rd_i;
    logic [PORT_W-1:0] sfr_wdata_i;
    logic [PORT_W-1:0] sfr_rdata_o;
    logic              sfr_hit_o;

    modport master (
        output sfr_addr_i, sfr_wr_i, sfr_rd_i, sfr_wdata_i,
        input  sfr_rdata_o, sfr_hit_o
    );

    modport slave (
        input  sfr_addr_i, sfr_wr_i, sfr_rd_i, sfr_wdata_i,
        output sfr_rdata_o, sfr_hit_o
    );

endinterface

// File: rtl/port_sync_edge.sv
// ---------------------------------------------------------------------------
// port_sync_edge
// Multi-flop synchronizer for an asynchronous pin vector, plus a history
// flop and per-bit rise/fall detection on the synchronized value.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   i_async        : raw pad value, asynchronous to clk_i
//   o_sync         : last synchronizer stage
//   o_rise         : o_sync high, history low
//   o_fall         : o_sync low, history high
// SYNC_STAGES is intended to be 2 or 3.
// ---------------------------------------------------------------------------
module port_sync_edge
    import port_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [PORT_W-1:0] i_async,
    output logic [PORT_W-1:0] o_sync,
    output logic [PORT_W-1:0] o_rise,
    output logic [PORT_W-1:0] o_fall
);

    logic [PORT_W-1:0] r_sync [SYNC_STAGES];
    logic [PORT_W-1:0] r_hist;

    // Plain reset flops: the chain input is never muxed with reset, so the
    // first stage samples the pad directly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_hist;
    assign o_fall = ~o_sync & r_hist;

endmodule

// File: rtl/port_sfr_ctrl.sv
// ---------------------------------------------------------------------------
// port_sfr_ctrl
// SFR register and control block for one 8-bit EMC08 GPIO port.
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   sfr              : CPU SFR bus (slave side)
//   ports_sfr_PX_o   : output latch to PORTS
//   ports_sfr_PXEN_o : pin direction to PORTS, 1 = output
//   ports_sfr_PX_i   : raw pad read value from PORTS (asynchronous)
//   port_irq_o       : registered port interrupt request
// Registers at BASE_ADDR+0..4: PX, PXEN, PXIE, PXIES, PXIF (W1C).
// ---------------------------------------------------------------------------
module port_sfr_ctrl
    import port_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'hC0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    port_sfr_ctrl_if.slave    sfr,
    output logic [PORT_W-1:0] ports_sfr_PX_o,
    output logic [PORT_W-1:0] ports_sfr_PXEN_o,
    input  logic [PORT_W-1:0] ports_sfr_PX_i,
    output logic              port_irq_o
);

    // Arm counter wide enough to reach SYNC_STAGES+1 (2 bits for the default).
    localparam int              ARM_MAX = SYNC_STAGES + 1;
    localparam int              CNT_W   = $clog2(ARM_MAX + 1);
    localparam logic [CNT_W-1:0] ARM_VAL = CNT_W'(ARM_MAX);

    logic [PORT_W-1:0] r_px;
    logic [PORT_W-1:0] r_pxen;
    logic [PORT_W-1:0] r_pxie;
    logic [PORT_W-1:0] r_pxies;
    logic [PORT_W-1:0] r_pxif;
    logic [PORT_W-1:0] r_rdata;
    logic              r_hit;
    logic              r_irq;
    logic [CNT_W-1:0]  r_arm_cnt;

    reg_sel_e          w_sel;
    logic              w_wr;
    logic              w_rd;
    logic [PORT_W-1:0] w_sync;
    logic [PORT_W-1:0] w_rise;
    logic [PORT_W-1:0] w_fall;
    logic [PORT_W-1:0] w_ev;
    logic [PORT_W-1:0] w_clr;
    logic [PORT_W-1:0] w_rd_val;
    logic              w_armed;

    port_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_async (ports_sfr_PX_i),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_sel = decode_reg(sfr.sfr_addr_i, BASE_ADDR);
    assign w_wr  = sfr.sfr_wr_i && (w_sel != REG_NONE);
    assign w_rd  = sfr.sfr_rd_i && (w_sel != REG_NONE);

    // Edges are ignored until the synchronizer has refilled after reset.
    assign w_armed = (r_arm_cnt == ARM_VAL);

    always_comb begin
        w_ev = '0;
        for (int i = 0; i < PORT_W; i++) begin
            w_ev[i] = ((r_pxies[i] == EDGE_FALL) ? w_fall[i] : w_rise[i])
                      & ~r_pxen[i] & w_armed;
        end
    end

    assign w_clr = (w_wr && (w_sel == REG_PXIF)) ? sfr.sfr_wdata_i : '0;

    // Output pins read back their latch, input pins read the synchronized pad.
    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            REG_PX:    w_rd_val = (r_pxen & r_px) | (~r_pxen & w_sync);
            REG_PXEN:  w_rd_val = r_pxen;
            REG_PXIE:  w_rd_val = r_pxie;
            REG_PXIES: w_rd_val = r_pxies;
            REG_PXIF:  w_rd_val = r_pxif;
            default:   w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_px    <= '0;
            r_pxen  <= '0;
            r_pxie  <= '0;
            r_pxies <= '0;
        end else if (w_wr) begin
            case (w_sel)
                REG_PX:    r_px    <= sfr.sfr_wdata_i;
                REG_PXEN:  r_pxen  <= sfr.sfr_wdata_i;
                REG_PXIE:  r_pxie  <= sfr.sfr_wdata_i;
                REG_PXIES: r_pxies <= sfr.sfr_wdata_i;
                default:   ;
            endcase
        end
    end

    // A new event wins over a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pxif <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pxif <= w_ev | (r_pxif & ~w_clr);
            r_irq  <= |(r_pxif & r_pxie);
        end
    end

    // Read data samples pre-edge register contents, so a same-cycle write
    // is not visible in it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else if (w_rd) begin
            r_rdata <= w_rd_val;
            r_hit   <= 1'b1;
        end else begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    assign sfr.sfr_rdata_o   = r_rdata;
    assign sfr.sfr_hit_o     = r_hit;
    assign ports_sfr_PX_o    = r_px;
    assign ports_sfr_PXEN_o  = r_pxen;
    assign port_irq_o        = r_irq;

endmodule

// File: doc/port_sfr_ctrl.md
Name: port_sfr_ctrl

Overview:
- SFR-side register and control block for one 8-bit GPIO port of the EMC08.
- Sits between the CPU SFR bus and the PORTS pad-mapping block.
- Holds the output latch (PX) and direction register (PXEN) that drive PORTS.
- Synchronizes the pad read value coming back from PORTS, serves CPU reads, and raises a per-pin edge interrupt.

Parameters:
- BASE_ADDR, 8'hC0: SFR address of PX. PXEN, PXIE, PXIES and PXIF follow at +1..+4.
- SYNC_STAGES, 2: flip-flop depth of the pad input synchronizer. Legal values are 2 or 3.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge
- rst_n_i  in  1  asynchronous reset, active-low
- sfr_addr_i  in  8  SFR address
- sfr_wr_i  in  1  write strobe, one cycle
- sfr_rd_i  in  1  read strobe, one cycle
- sfr_wdata_i  in  8  write data
- sfr_rdata_o  out  8  read data, registered
- sfr_hit_o  out  1  registered; high the cycle sfr_rdata_o is valid for this block
- ports_sfr_PX_o  out  8  output latch to PORTS
- ports_sfr_PXEN_o  out  8  direction to PORTS; 1 = output, 0 = input
- ports_sfr_PX_i  in  8  raw pad read value from PORTS (asynchronous to clk_i)
- port_irq_o  out  1  port interrupt request, registered

Behaviour:
- **Clocking and reset:** one clock; reset is asynchronous and active-low (clk_i, rst_n_i).
- **Reset values:**
  - PX = PXEN = PXIE = PXIES = PXIF = 8'h00, so all pins come up as inputs.
  - Synchronizer and edge-history flops = 0.
  - sfr_rdata_o = 0, sfr_hit_o = 0, port_irq_o = 0.
  - arm counter = 0.
- **Register map** (offset from BASE_ADDR):
  - 0 PX: read/write.
  - 1 PXEN: read/write.
  - 2 PXIE: read/write.
  - 3 PXIES: read/write; per bit, 0 = rising edge, 1 = falling edge.
  - 4 PXIF: read; write-1-to-clear.
  - Other addresses are ignored: no write, no hit.
- **Writes:** when sfr_wr_i is high at a matching address, the register updates on that clock edge, and its output is visible in the next cycle.
- **Write/read priority:** sfr_wr_i and sfr_rd_i high together is a write followed by a read of the old value. The read returns the pre-write contents.
- **Read latency:** when sfr_rd_i is high at a matching address, sfr_rdata_o and sfr_hit_o are valid in the next cycle, for one cycle only. Otherwise sfr_rdata_o = 8'h00 and sfr_hit_o = 0.
- **PX read value:** per bit, PXEN[i] ? PX[i] : sync[i], where sync is the last synchronizer stage. Read-modify-write of PX therefore keeps output bits at their latched value.
- **Synchronizer:** SYNC_STAGES flops per bit with no reset-mux glitching. A pad change is visible in a PX read after SYNC_STAGES+1 edges.
- **Edge detection:**
  - hist <= sync every cycle.
  - rise[i] = sync & ~hist; fall[i] = ~sync & hist.
  - ev[i] = (PXIES[i] ? fall : rise) & ~PXEN[i] & armed.
  - Output pins never set flags.
- **Flags:** PXIF[i] <= ev[i] | (PXIF[i] & ~clr[i]), where clr = the write data of a PXIF write. An event in the same cycle as a clear leaves the flag set, so a set always beats a clear.
- **Flag independence:** flags are set regardless of PXIE.
- **Interrupt:** port_irq_o <= |(PXIF & PXIE). Latency is one cycle after the flag sets.
- **Arm counter:**
  - 2-bit saturating counter, incremented every cycle after reset.
  - armed = (count == SYNC_STAGES+1), which suppresses spurious edges while the synchronizer fills.
  - The count saturates and holds.
- **Reset mid-operation:** asynchronously returns all state to the reset values. armed drops immediately and re-arms SYNC_STAGES+1 cycles after rst_n_i rises.
- **Direction change:** changing a pin output→input does not by itself generate an event beyond a genuine sync/hist difference.

Decomposition:
- **Shared package port_pkg:**
  - register offset constants: PX_OFS=0, PXEN_OFS=1, PXIE_OFS=2, PXIES_OFS=3, PXIF_OFS=4
  - EDGE_RISE=0, EDGE_FALL=1
  - port width constant 8
- **Sub-module port_sync_edge:** the synchronizer, the history flop and the rise/fall outputs for one 8-bit vector, parameterized by SYNC_STAGES.
- **Top level:** the register file, read mux, flags and arm counter.

Test Plan:
1. **Reset:** assert rst_n_i low mid-traffic → all outputs 0 and PXEN_o = 8'h00. Read PX with pads = 8'hA5 → 8'hA5 after sync.
2. **Write then read:** write PXEN=8'hF0, PX=8'h3C, pads=8'h0A.
   - ports_sfr_PX_o = 8'h3C and ports_sfr_PXEN_o = 8'hF0 next cycle.
   - Read PX → 8'h3A, with sfr_hit_o high exactly one cycle.
3. **Rising-edge interrupt:** PXEN=0, PXIE=8'h01, PXIES=0, then pin0 goes 0→1.
   - PXIF=8'h01 at SYNC_STAGES+1 edges.
   - port_irq_o high one cycle later.
   - Write PXIF=8'h01 → flag and irq clear.
4. **Set/clear collision and masking:**
   - Falling edge on pin3 (PXIES[3]=1) arrives in the same cycle as a PXIF write of 8'h08 → PXIF[3] stays 1.
   - Output pin (PXEN[5]=1) toggling pad5 → PXIF[5] stays 0.
5. **Post-reset arming:** hold pads = 8'hFF through reset release → PXIF stays 8'h00 and there is no irq. A later 1→0 on pin7 with PXIES[7]=1 sets PXIF[7].
6. **Address decode:** write 8'hFF to BASE_ADDR+5 and to BASE_ADDR-1 → no register changes and sfr_hit_o stays 0. Simultaneous write and read of PXIE returns the old value.
